fft8_twiddle_sequencer: RTL and testbench
=========================================

# fft8_twiddle_sequencer

Control-side partner of the 8-point FFT twiddle LUTs (`FFT8_LUT_Re` / `FFT8_LUT_Im`). After a `Start` pulse it walks the 12 butterflies of an in-place radix-2 DIT 8-point FFT: 3 stages × 4 butterflies, with bit-reversed input order. For each butterfly it drives the LUT `address`, registers the returned coefficient pair, and presents it to the butterfly datapath with the operand indices under a Valid/Ready handshake. It sits between the LUTs and the butterfly/memory unit in the tuner's spectrum path.

## Interface
- `COEFF_WIDTH`, 16 — width of LUT coefficients, signed Q1.15.
- `INVERSE`, 0 — when 1, outputs the conjugate twiddle for IFFT use.

- `Clk`  in  1  — system clock, rising edge.
- `Reset`  in  1  — asynchronous, active-high reset.
- `Start`  in  1  — begin a transform; sampled only in IDLE.
- `Ready`  in  1  — datapath accepts the current butterfly.
- `coeff_real_in`  in  COEFF_WIDTH  — from `FFT8_LUT_Re.coefficient`, combinational on `lut_address`.
- `coeff_imag_in`  in  COEFF_WIDTH  — from `FFT8_LUT_Im.coefficient`.
- `lut_address`  out  3  — drives both LUT `address` ports.
- `Valid`  out  1  — butterfly descriptor is valid.
- `index_a`, `index_b`  out  3 each  — butterfly operand indices.
- `stage`  out  2  — current stage, 0..2.
- `tw_real`, `tw_imag`  out  COEFF_WIDTH  — registered twiddle.
- `Busy`  out  1  — high in LOAD and WAIT.
- `Done`  out  1  — one-cycle pulse when the transform finishes.

## Operation
- Counters: `stage` s (0..2) and butterfly b (0..3). span = 1<<s, j = b mod span, g = b / span.
  - Address and index generation: `index_a` = 2·g·span + j; `index_b` = `index_a` + span; `lut_address` k = j·(4>>s).
  - Stage 0: a = 0,2,4,6; b = 1,3,5,7; k = 0.
  - Stage 1: (a,b,k) = (0,2,0), (1,3,2), (4,6,0), (5,7,2).
  - Stage 2: a = 0..3, b = 4..7, k = 0..3.
- FSM states: IDLE, LOAD, WAIT, DONE.
  - IDLE: `lut_address`=0, all outputs 0. `Start`=1 → LOAD with s=b=0.
  - LOAD: drive `lut_address` = k(s,b). On the clock edge, capture the coefficients, `index_a`, `index_b` and `stage` into the output registers, set `Valid`=1, and go to WAIT.
  - WAIT: hold all outputs stable. On `Valid`&&`Ready`:
    - if s=2 and b=3, clear `Valid` and go to DONE;
    - otherwise clear `Valid`, advance b (on wrap b→0, s+1), and go to LOAD.
  - DONE: `Done`=1 for exactly one cycle, then IDLE.
- `Start` is ignored outside IDLE. `Start` held high continuously restarts a transform on every return to IDLE.
- `Ready` is ignored while `Valid`=0.
- Arithmetic:
  - `tw_real` = `coeff_real_in` unchanged.
  - `tw_imag` = `coeff_imag_in` when `INVERSE`=0.
  - When `INVERSE`=1, `tw_imag` is the two's-complement negation of `coeff_imag_in`, saturating: most-negative (0x8000) → 0x7FFF.
- Reset (any time, including mid-transform): state IDLE; `Valid`, `Busy`, `Done`, `index_a`, `index_b`, `stage`, `lut_address`, `tw_real`, `tw_imag` all 0. The partial transform is abandoned, with no `Done`.

## Timing
- LUTs are combinational, so the coefficient is captured in the same cycle `lut_address` is driven.
- `Start` sampled at edge E0 → LOAD during E0–E1 → `Valid`=1 after E1.
- Each accepted butterfly costs 2 cycles minimum: LOAD plus one WAIT cycle with `Ready`=1. `Valid` is low during each LOAD cycle.
- With `Ready` tied high: 12th acceptance at E24, `Done`=1 during E24–E25, IDLE after E25.
- Minimum Start-to-Start period: 26 cycles.
- Backpressure: each cycle of `Ready`=0 in WAIT adds one cycle. Outputs do not change while stalled.

## Test plan
The bench uses a LUT stub: `coeff_real_in` = 0x1000+address, `coeff_imag_in` = 0x2000+address.
1. Reset asserted mid-cycle, with no `Clk` edge → all outputs 0 immediately; state IDLE.
2. `Start` pulse, `Ready`=1, `INVERSE`=0 → 12 descriptors in the order given above; the 6th is (stage 1, a=1, b=3, `tw_real`=0x1002, `tw_imag`=0x2002). `Done` pulses after E24. `Busy` falls with `Done`.
3. `Ready`=0 for 5 cycles on butterfly 3 → `Valid` held, all outputs frozen, `lut_address` unchanged; completion delayed exactly 5 cycles.
4. `INVERSE`=1 with the stub imag = 0x8000 at address 0 and 0xA57E at address 1 → `tw_imag` = 0x7FFF and 0x5A82 respectively.
5. `Reset` pulsed during stage 1, then `Start` → no `Done` for the aborted run; the new run begins at stage 0, a=0, b=1.
6. `Start` held high throughout → second transform's first `Valid` appears 2 cycles after the first run's `Done`. `Start` pulses during Busy are ignored.

Source files
------------

// File: rtl/fft8_twiddle_sequencer.sv
// Twiddle sequencer for an in-place radix-2 DIT 8-point FFT: walks 3 stages x 4
// butterflies, addresses the twiddle LUTs and hands each descriptor to the datapath.
module fft8_twiddle_sequencer #(
  parameter int COEFF_WIDTH = 16,
  parameter bit INVERSE     = 1'b0
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   Ready,
  input  logic [COEFF_WIDTH-1:0] coeff_real_in,
  input  logic [COEFF_WIDTH-1:0] coeff_imag_in,
  output logic [2:0]             lut_address,
  output logic                   Valid,
  output logic [2:0]             index_a,
  output logic [2:0]             index_b,
  output logic [1:0]             stage,
  output logic [COEFF_WIDTH-1:0] tw_real,
  output logic [COEFF_WIDTH-1:0] tw_imag,
  output logic                   Busy,
  output logic                   Done,
  output logic [1:0]             fsm_state
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t state, state_next;
  logic [1:0] s_cnt, b_cnt;
  logic [2:0] a_calc, b_calc, k_calc, span;
  logic [COEFF_WIDTH-1:0] imag_adj;
  logic last;

  // Operand indices and twiddle address for butterfly b_cnt of stage s_cnt.
  always_comb begin
    a_calc = 3'd0;
    k_calc = 3'd0;
    span   = 3'd1 << s_cnt;
    case (s_cnt)
      2'd0: begin
        a_calc = {b_cnt, 1'b0};
        k_calc = 3'd0;
      end
      2'd1: begin
        a_calc = {b_cnt[1], 1'b0, b_cnt[0]};
        k_calc = {1'b0, b_cnt[0], 1'b0};
      end
      default: begin
        a_calc = {1'b0, b_cnt};
        k_calc = {1'b0, b_cnt};
      end
    endcase
    b_calc = a_calc + span;
  end

  // Conjugation for IFFT; the most-negative code saturates instead of wrapping.
  always_comb begin
    imag_adj = coeff_imag_in;
    if (INVERSE) begin
      if (coeff_imag_in == {1'b1, {(COEFF_WIDTH-1){1'b0}}})
        imag_adj = {1'b0, {(COEFF_WIDTH-1){1'b1}}};
      else
        imag_adj = '0 - coeff_imag_in;
    end
  end

  assign last = (s_cnt == 2'd2) && (b_cnt == 2'd3);

  // Handshake: Valid rises after the LOAD edge and stays high with every
  // descriptor output frozen until the edge where Valid && Ready; Ready is
  // ignored while Valid is low.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = LOAD;
      LOAD:    state_next = WAIT;
      WAIT:    if (Ready) state_next = last ? DONE : LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s_cnt <= 2'd0;
      b_cnt <= 2'd0;
    end else if (state == IDLE && Start) begin
      s_cnt <= 2'd0;
      b_cnt <= 2'd0;
    end else if (state == WAIT && Ready && !last) begin
      b_cnt <= b_cnt + 2'd1;
      if (b_cnt == 2'd3) s_cnt <= s_cnt + 2'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      index_a <= 3'd0;
      index_b <= 3'd0;
      stage   <= 2'd0;
      tw_real <= '0;
      tw_imag <= '0;
    end else if (state == LOAD) begin
      index_a <= a_calc;
      index_b <= b_calc;
      stage   <= s_cnt;
      tw_real <= coeff_real_in;
      tw_imag <= imag_adj;
    end else if (state == DONE) begin
      // Leave IDLE with every descriptor output at zero.
      index_a <= 3'd0;
      index_b <= 3'd0;
      stage   <= 2'd0;
      tw_real <= '0;
      tw_imag <= '0;
    end
  end

  assign Valid       = (state == WAIT);
  assign Busy        = (state == LOAD) || (state == WAIT);
  assign Done        = (state == DONE);
  assign lut_address = Busy ? k_calc : 3'd0;
  assign fsm_state   = state;

endmodule

// File: tb/tb_fft8_twiddle_sequencer.sv
// Bench for fft8_twiddle_sequencer: a forward and an inverse instance run in lockstep
// against a butterfly-order model derived from the radix-2 DIT index rules.
module tb_fft8_twiddle_sequencer;
  localparam int W = 16;

  typedef struct packed {
    logic [1:0]   stage;
    logic [2:0]   a;
    logic [2:0]   b;
    logic [2:0]   k;
    logic [W-1:0] tr;
    logic [W-1:0] ti;
    logic [W-1:0] ti_inv;
  } desc_t;

  logic Clk = 1'b0;
  logic Reset, Start, Ready;
  logic [W-1:0] cr0, ci0, cr1, ci1;
  logic [2:0] la0, la1, ia0, ia1, ib0, ib1;
  logic [1:0] st0, st1, fs0, fs1;
  logic [W-1:0] tr0, tr1, ti0, ti1;
  logic v0, v1, busy0, busy1, done0, done1;

  int vectors = 0;
  int miscompares = 0;
  bit stub_mode = 1'b0;
  desc_t exp_q[$];

  always #5 Clk = ~Clk;

  fft8_twiddle_sequencer #(.COEFF_WIDTH(W), .INVERSE(1'b0)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ready(Ready),
    .coeff_real_in(cr0), .coeff_imag_in(ci0), .lut_address(la0), .Valid(v0),
    .index_a(ia0), .index_b(ib0), .stage(st0), .tw_real(tr0), .tw_imag(ti0),
    .Busy(busy0), .Done(done0), .fsm_state(fs0));

  fft8_twiddle_sequencer #(.COEFF_WIDTH(W), .INVERSE(1'b1)) dut_inv (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ready(Ready),
    .coeff_real_in(cr1), .coeff_imag_in(ci1), .lut_address(la1), .Valid(v1),
    .index_a(ia1), .index_b(ib1), .stage(st1), .tw_real(tr1), .tw_imag(ti1),
    .Busy(busy1), .Done(done1), .fsm_state(fs1));

  // LUT stub; mode 1 plants the saturation corner cases at addresses 0 and 1.
  function automatic logic [W-1:0] stub_imag(input logic [2:0] addr);
    if (stub_mode && addr == 3'd0) return 16'h8000;
    if (stub_mode && addr == 3'd1) return 16'hA57E;
    return 16'h2000 + 16'(addr);
  endfunction

  always_comb begin
    cr0 = 16'h1000 + 16'(la0);
    cr1 = 16'h1000 + 16'(la1);
    ci0 = stub_imag(la0);
    ci1 = stub_imag(la1);
  end

  function automatic logic [W-1:0] sat_neg(input logic [W-1:0] v);
    int x;
    x = int'($signed(v));
    if (x == -32768) return 16'h7FFF;
    return 16'(-x);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_model();
    desc_t d;
    int s, bi, span, j, g, a, k;
    exp_q.delete();
    for (int n = 0; n < 12; n++) begin
      s = n / 4;
      bi = n % 4;
      span = 1 << s;
      j = bi % span;
      g = bi / span;
      a = 2 * g * span + j;
      k = j * (4 >> s);
      d.stage  = 2'(s);
      d.a      = 3'(a);
      d.b      = 3'(a + span);
      d.k      = 3'(k);
      d.tr     = 16'h1000 + 16'(k);
      d.ti     = stub_imag(3'(k));
      d.ti_inv = sat_neg(d.ti);
      exp_q.push_back(d);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_lut"}, la0, 0);
    check({tag, "_lut_inv"}, la1, 0);
    check({tag, "_valid"}, v0, 0);
    check({tag, "_busy"}, busy0, 0);
    check({tag, "_done"}, done0, 0);
    check({tag, "_idx_a"}, ia0, 0);
    check({tag, "_idx_b"}, ib0, 0);
    check({tag, "_stage"}, st0, 0);
    check({tag, "_tw_re"}, tr0, 0);
    check({tag, "_tw_im"}, ti0, 0);
    check({tag, "_tw_im_inv"}, ti1, 0);
    check({tag, "_fsm_idle"}, fs0, 0);
    check({tag, "_fsm_idle_inv"}, fs1, 0);
  endtask

  task automatic pulse_start();
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Entered at the negedge of the first LOAD cycle; returns at the Done negedge,
  // or at the first negedge showing butterfly abort_n.
  task automatic run_body(input int stall_n, input int stall_len, input bit rand_ready,
                          input bit noisy_start, input bit hold_start, input int abort_n);
    int cyc, stalls, stall_ctr, n;
    bit in_load, rdy;
    desc_t d;
    build_model();
    cyc = 1; stalls = 0; stall_ctr = 0; n = 0; in_load = 1'b1;
    for (int guard = 0; guard < 300; guard++) begin
      if (n == abort_n) return;
      if (n == 12) begin
        check("done_pulse", done0, 1);
        check("done_busy", busy0, 0);
        check("done_valid", v0, 0);
        check("done_inv", done1, 1);
        check("latency", cyc, 25 + stalls);
        if (!hold_start) Start = 1'b0;
        return;
      end
      d = exp_q[0];
      check("busy", busy0, 1);
      check("done_low", done0, 0);
      check("valid", v0, !in_load);
      check("valid_inv", v1, !in_load);
      check("lut_addr", la0, d.k);
      check("lut_addr_inv", la1, d.k);
      if (!in_load) begin
        check("index_a", ia0, d.a);
        check("index_b", ib0, d.b);
        check("stage", st0, d.stage);
        check("tw_real", tr0, d.tr);
        check("tw_imag", ti0, d.ti);
        check("tw_imag_inv", ti1, d.ti_inv);
      end
      rdy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!in_load && n == stall_n && stall_ctr < stall_len) begin
        rdy = 1'b0;
        stall_ctr++;
      end
      if (in_load) rdy = 1'($urandom_range(0, 1));
      if (!in_load && !rdy) stalls++;
      Ready = rdy;
      if (noisy_start) Start = 1'($urandom_range(0, 1));
      @(posedge Clk);
      if (!in_load && rdy) begin
        n++;
        void'(exp_q.pop_front());
        in_load = 1'b1;
      end else if (in_load) begin
        in_load = 1'b0;
      end
      @(negedge Clk);
      cyc++;
    end
    check("run_budget", n, 12);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b0; Start = 1'b0; Ready = 1'b0;
    // Reset raised between edges must clear outputs without a clock.
    #2 Reset = 1'b1;
    #1 check_idle("rst_async");
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check_idle("idle");

    // Ready tied high: nominal order and 25-cycle Done timing.
    pulse_start();
    run_body(-1, 0, 1'b0, 1'b0, 1'b0, -1);
    @(posedge Clk); @(negedge Clk);
    check_idle("after_run");

    // Five-cycle stall on the third butterfly.
    pulse_start();
    run_body(2, 5, 1'b0, 1'b0, 1'b0, -1);
    @(posedge Clk); @(negedge Clk);
    check_idle("after_stall");

    // Random backpressure with Start noise while busy.
    repeat (2) begin
      pulse_start();
      run_body(-1, 0, 1'b1, 1'b1, 1'b0, -1);
      @(posedge Clk); @(negedge Clk);
      check_idle("after_rand");
    end

    // Saturating conjugate corner cases.
    stub_mode = 1'b1;
    pulse_start();
    run_body(-1, 0, 1'b1, 1'b0, 1'b0, -1);
    @(posedge Clk); @(negedge Clk);
    check_idle("after_inv");
    stub_mode = 1'b0;

    // Reset in stage 1 abandons the run; the next run starts from the top.
    pulse_start();
    run_body(-1, 0, 1'b1, 1'b1, 1'b0, 5);
    check("abort_stage", st0, 1);
    Start = 1'b0;
    #1 Reset = 1'b1;
    #1 check_idle("rst_mid");
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      check("no_done_after_abort", done0, 0);
      check("idle_after_abort", busy0, 0);
    end
    pulse_start();
    run_body(-1, 0, 1'b0, 1'b0, 1'b0, -1);
    @(posedge Clk); @(negedge Clk);
    check_idle("after_restart");

    // Start held high: back-to-back transforms.
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk); @(negedge Clk);
    run_body(-1, 0, 1'b0, 1'b0, 1'b1, -1);
    @(posedge Clk); @(negedge Clk);
    check("hold_gap_valid", v0, 0);
    check("hold_gap_busy", busy0, 0);
    check("hold_gap_done", done0, 0);
    @(posedge Clk); @(negedge Clk);
    run_body(-1, 0, 1'b0, 1'b0, 1'b0, -1);
    @(posedge Clk); @(negedge Clk);
    check_idle("after_hold");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
